// File: rtl/usb_stream_pkg.sv
// Shared FSM encoding and constants for usb_stream_arb.
// StTag is only part of the encoding when USB_STREAM_ARB_TAG_EN is defined.
package usb_stream_pkg;

  localparam logic [7:0]  TAG_BASE = 8'hF0;
  localparam int unsigned CNT_W    = 8;

`ifdef USB_STREAM_ARB_TAG_EN
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTag   = 2'd1,
    StBurst = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first request found
// searching upward (with wrap) from index ptr.
module usb_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (j == (32'(ptr) + i) % N_REQ)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/usb_stream_arb.sv
// Round-robin arbiter merging N_REQ byte streams into one USB CDC TX stream.
// Define USB_STREAM_ARB_TAG_EN to prefix each grant with a tag byte (F0 | owner).
module usb_stream_arb
  import usb_stream_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_val,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_rdy,
  output logic [7:0]         tx_data,
  output logic               tx_val,
  input  logic               tx_rdy,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int unsigned      PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [PW-1:0]    LAST_IDX  = PW'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d, pick;
  logic [PW-1:0]      ptr_q, ptr_d, owner_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [7:0]         tx_data_q, tx_data_d, owner_data;
  logic               tx_val_q, tx_val_d;
  logic               owner_last, slot_free, accept, burst_done;

  // ptr_q holds the highest-priority index, i.e. (last owner + 1) mod N_REQ.
  usb_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req (req_val),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    owner_last = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = PW'(i);
        owner_data = req_data[8*i +: 8];
        owner_last = req_last[i];
      end
    end
  end

  assign slot_free  = !tx_val_q || tx_rdy;
  assign req_rdy    = (state_q == StBurst && slot_free) ? (grant_q & req_val) : '0;
  assign accept     = |req_rdy;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign burst_done = owner_last || (cnt_inc == BURST_MAX);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    // The output stage drains on its own, regardless of the FSM state.
    tx_val_d  = tx_val_q && !tx_rdy;

    unique case (state_q)
      StIdle: begin
        if (|req_val) begin
          grant_d = pick;
          cnt_d   = '0;
`ifdef USB_STREAM_ARB_TAG_EN
          state_d = StTag;
`else
          state_d = StBurst;
`endif
        end
      end
`ifdef USB_STREAM_ARB_TAG_EN
      StTag: begin
        if (slot_free) begin
          tx_data_d = TAG_BASE | 8'(owner_idx);
          tx_val_d  = 1'b1;
          state_d   = StBurst;
        end
      end
`endif
      StBurst: begin
        if (accept) begin
          tx_data_d = owner_data;
          tx_val_d  = 1'b1;
          cnt_d     = cnt_inc;
          if (burst_done) begin
            state_d = StIdle;
            grant_d = '0;
            ptr_d   = (owner_idx == LAST_IDX) ? '0 : owner_idx + PW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      tx_val_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_val_q  <= tx_val_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_val  = tx_val_q;
  assign grant   = grant_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_usb_stream_arb.sv
// Directed bench for usb_stream_arb (N_REQ=2, MAX_BURST=4); expected streams
// include tag bytes when USB_STREAM_ARB_TAG_EN is defined.
module tb_usb_stream_arb;

`ifdef USB_STREAM_ARB_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req_data = '0;
  logic [1:0]  req_val = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_rdy;
  logic [7:0]  tx_data;
  logic        tx_val;
  logic        tx_rdy = 1'b0;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int passes = 0;

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  bit         hold0 = 1'b0;
  logic [7:0] tx_got[$];
  int         grant_got[$];
  logic [1:0] grant_prev = '0;

  usb_stream_arb #(
    .N_REQ     (2),
    .MAX_BURST (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_data (req_data),
    .req_val  (req_val),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .tx_data  (tx_data),
    .tx_val   (tx_val),
    .tx_rdy   (tx_rdy),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Sources pop on acceptance and present their next byte on the falling edge.
  always @(posedge clk) begin
    if (!rst && req_val[0] && req_rdy[0] && src0.size() > 0) void'(src0.pop_front());
    if (!rst && req_val[1] && req_rdy[1] && src1.size() > 0) void'(src1.pop_front());
    if (!rst && tx_val && tx_rdy) tx_got.push_back(tx_data);
    if (!rst && grant != 2'b00 && grant_prev == 2'b00) grant_got.push_back(grant[1] ? 1 : 0);
    grant_prev = grant;
  end

  always @(negedge clk) begin
    if (src0.size() > 0) begin
      req_val[0] = !hold0; req_last[0] = src0[0][8]; req_data[7:0] = src0[0][7:0];
    end else begin
      req_val[0] = 1'b0; req_last[0] = 1'b0; req_data[7:0] = 8'h00;
    end
    if (src1.size() > 0) begin
      req_val[1] = 1'b1; req_last[1] = src1[0][8]; req_data[15:8] = src1[0][7:0];
    end else begin
      req_val[1] = 1'b0; req_last[1] = 1'b0; req_data[15:8] = 8'h00;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    src0.delete(); src1.delete(); hold0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tx_got.delete(); grant_got.delete();
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (src0.size() == 0 && src1.size() == 0 && !tx_val) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || req_rdy !== 2'b00)
      $display("FAIL reset_ctrl: grant=%b busy=%b rdy=%b, want 00 0 00", grant, busy, req_rdy);
    else passes++;
    checks++;
    if (tx_val !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL reset_tx: tx_val=%b tx_data=%h, want 0 00", tx_val, tx_data);
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || grant !== 2'b00)
      $display("FAIL reset_idle: busy=%b grant=%b, want 0 00", busy, grant);
    else passes++;
  endtask

  task automatic test_single();
    logic [7:0] want[$];
    logic [7:0] got;
    bit ok;
    tx_rdy = 1'b1;
    tx_got.delete(); grant_got.delete();
    src0.push_back({1'b0, 8'h41}); src0.push_back({1'b0, 8'h42}); src0.push_back({1'b1, 8'h43});
    wait_drain(ok);
    checks++;
    if (!ok) $display("FAIL single_drain: timed out"); else passes++;
    if (TAG) want.push_back(8'hF0);
    want.push_back(8'h41); want.push_back(8'h42); want.push_back(8'h43);
    checks++;
    if (tx_got.size() != want.size())
      $display("FAIL single_count: got %0d bytes want %0d", tx_got.size(), want.size());
    else passes++;
    for (int k = 0; k < want.size(); k++) begin
      got = (k < tx_got.size()) ? tx_got[k] : 8'hxx;
      checks++;
      if (got !== want[k]) $display("FAIL single_byte%0d: got %h want %h", k, got, want[k]);
      else passes++;
    end
    checks++;
    if (grant_got.size() != 1 || grant_got[0] != 0 || grant !== 2'b00 || busy !== 1'b0)
      $display("FAIL single_grant: grants=%0d grant=%b busy=%b, want 1 grant to 0 then 00 0",
               grant_got.size(), grant, busy);
    else passes++;
  endtask

  task automatic test_contention();
    logic [7:0] want[$];
    logic [7:0] got;
    int want_g[$];
    bit ok;
    apply_reset();
    src0.push_back({1'b0, 8'hA0}); src0.push_back({1'b1, 8'hA1});
    src0.push_back({1'b0, 8'hA2}); src0.push_back({1'b1, 8'hA3});
    src1.push_back({1'b0, 8'hB0}); src1.push_back({1'b1, 8'hB1});
    src1.push_back({1'b0, 8'hB2}); src1.push_back({1'b1, 8'hB3});
    wait_drain(ok);
    checks++;
    if (!ok) $display("FAIL cont_drain: timed out"); else passes++;
    if (TAG) want.push_back(8'hF0);
    want.push_back(8'hA0); want.push_back(8'hA1);
    if (TAG) want.push_back(8'hF1);
    want.push_back(8'hB0); want.push_back(8'hB1);
    if (TAG) want.push_back(8'hF0);
    want.push_back(8'hA2); want.push_back(8'hA3);
    if (TAG) want.push_back(8'hF1);
    want.push_back(8'hB2); want.push_back(8'hB3);
    checks++;
    if (tx_got.size() != want.size())
      $display("FAIL cont_count: got %0d bytes want %0d", tx_got.size(), want.size());
    else passes++;
    for (int k = 0; k < want.size(); k++) begin
      got = (k < tx_got.size()) ? tx_got[k] : 8'hxx;
      checks++;
      if (got !== want[k]) $display("FAIL cont_byte%0d: got %h want %h", k, got, want[k]);
      else passes++;
    end
    want_g = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= grant_got.size() || grant_got[k] != want_g[k])
        $display("FAIL cont_grant%0d: got %0d want %0d", k,
                 (k < grant_got.size()) ? grant_got[k] : -1, want_g[k]);
      else passes++;
    end
  endtask

  task automatic test_burst_cap();
    logic [7:0] want[$];
    logic [7:0] got;
    int want_g[$];
    bit ok;
    bit seen;
    apply_reset();
    for (int k = 0; k < 10; k++) src1.push_back({1'b0, 8'hD0 + 8'(k)});
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (grant === 2'b10) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL cap_first_grant: grant=%b, want 10", grant); else passes++;
    src0.push_back({1'b0, 8'hC0}); src0.push_back({1'b1, 8'hC1});
    wait_drain(ok);
    checks++;
    if (!ok) $display("FAIL cap_drain: timed out"); else passes++;
    if (TAG) want.push_back(8'hF1);
    for (int k = 0; k < 4; k++) want.push_back(8'hD0 + 8'(k));
    if (TAG) want.push_back(8'hF0);
    want.push_back(8'hC0); want.push_back(8'hC1);
    if (TAG) want.push_back(8'hF1);
    for (int k = 4; k < 8; k++) want.push_back(8'hD0 + 8'(k));
    if (TAG) want.push_back(8'hF1);
    want.push_back(8'hD8); want.push_back(8'hD9);
    checks++;
    if (tx_got.size() != want.size())
      $display("FAIL cap_count: got %0d bytes want %0d", tx_got.size(), want.size());
    else passes++;
    for (int k = 0; k < want.size(); k++) begin
      got = (k < tx_got.size()) ? tx_got[k] : 8'hxx;
      checks++;
      if (got !== want[k]) $display("FAIL cap_byte%0d: got %h want %h", k, got, want[k]);
      else passes++;
    end
    want_g = '{1, 0, 1, 1};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= grant_got.size() || grant_got[k] != want_g[k])
        $display("FAIL cap_grant%0d: got %0d want %0d", k,
                 (k < grant_got.size()) ? grant_got[k] : -1, want_g[k]);
      else passes++;
    end
    // Message never ended: owner keeps the grant with no data pending.
    checks++;
    if (grant !== 2'b10 || busy !== 1'b1)
      $display("FAIL cap_hold: grant=%b busy=%b, want 10 1", grant, busy);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0] want[$];
    logic [7:0] got;
    logic [7:0] hold_byte;
    bit ok;
    bit seen;
    apply_reset();
    tx_rdy = 1'b1;
    src0.push_back({1'b0, 8'h10}); src0.push_back({1'b0, 8'h11}); src0.push_back({1'b1, 8'h12});
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tx_got.size() >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL bp_first: no transfer seen"); else passes++;
    tx_rdy = 1'b0;
    hold_byte = TAG ? 8'h10 : 8'h11;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (tx_val !== 1'b1 || tx_data !== hold_byte || req_rdy !== 2'b00)
        $display("FAIL bp_stall%0d: tx_val=%b tx_data=%h rdy=%b, want 1 %h 00",
                 c, tx_val, tx_data, req_rdy, hold_byte);
      else passes++;
      @(posedge clk);
    end
    #1 tx_rdy = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok) $display("FAIL bp_drain: timed out"); else passes++;
    if (TAG) want.push_back(8'hF0);
    want.push_back(8'h10); want.push_back(8'h11); want.push_back(8'h12);
    checks++;
    if (tx_got.size() != want.size())
      $display("FAIL bp_count: got %0d bytes want %0d", tx_got.size(), want.size());
    else passes++;
    for (int k = 0; k < want.size(); k++) begin
      got = (k < tx_got.size()) ? tx_got[k] : 8'hxx;
      checks++;
      if (got !== want[k]) $display("FAIL bp_byte%0d: got %h want %h", k, got, want[k]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] want[$];
    logic [7:0] got;
    bit ok;
    bit seen;
    tx_rdy = 1'b0;
    tx_got.delete(); grant_got.delete();
    src1.push_back({1'b0, 8'h50}); src1.push_back({1'b0, 8'h51}); src1.push_back({1'b1, 8'h52});
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tx_val === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || grant !== 2'b10) $display("FAIL rmid_setup: tx_val=%b grant=%b, want 1 10", tx_val, grant);
    else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || req_rdy !== 2'b00 || tx_val !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL rmid_outputs: grant=%b busy=%b rdy=%b tx_val=%b tx_data=%h, want 00 0 00 0 00",
               grant, busy, req_rdy, tx_val, tx_data);
    else passes++;
    src1.delete();
    rst = 1'b0;
    tx_rdy = 1'b1;
    tx_got.delete(); grant_got.delete();
    src0.push_back({1'b1, 8'h60});
    src1.push_back({1'b1, 8'h70});
    wait_drain(ok);
    checks++;
    if (!ok) $display("FAIL rmid_drain: timed out"); else passes++;
    checks++;
    if (grant_got.size() < 2 || grant_got[0] != 0 || grant_got[1] != 1)
      $display("FAIL rmid_order: first grant %0d, want 0 then 1",
               (grant_got.size() > 0) ? grant_got[0] : -1);
    else passes++;
    if (TAG) want.push_back(8'hF0);
    want.push_back(8'h60);
    if (TAG) want.push_back(8'hF1);
    want.push_back(8'h70);
    checks++;
    if (tx_got.size() != want.size())
      $display("FAIL rmid_count: got %0d bytes want %0d", tx_got.size(), want.size());
    else passes++;
    for (int k = 0; k < want.size(); k++) begin
      got = (k < tx_got.size()) ? tx_got[k] : 8'hxx;
      checks++;
      if (got !== want[k]) $display("FAIL rmid_byte%0d: got %h want %h", k, got, want[k]);
      else passes++;
    end
  endtask

  task automatic test_owner_gap();
    logic [7:0] want[$];
    logic [7:0] got;
    bit ok;
    bit seen;
    tx_got.delete(); grant_got.delete();
    src0.push_back({1'b0, 8'h20}); src0.push_back({1'b0, 8'h21}); src0.push_back({1'b1, 8'h22});
    src1.push_back({1'b1, 8'h30});
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (src0.size() == 2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL gap_first: first byte never accepted"); else passes++;
    hold0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (grant !== 2'b01 || busy !== 1'b1 || req_rdy !== 2'b00)
        $display("FAIL gap_hold%0d: grant=%b busy=%b rdy=%b, want 01 1 00", c, grant, busy, req_rdy);
      else passes++;
    end
    hold0 = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) $display("FAIL gap_drain: timed out"); else passes++;
    if (TAG) want.push_back(8'hF0);
    want.push_back(8'h20); want.push_back(8'h21); want.push_back(8'h22);
    if (TAG) want.push_back(8'hF1);
    want.push_back(8'h30);
    checks++;
    if (tx_got.size() != want.size())
      $display("FAIL gap_count: got %0d bytes want %0d", tx_got.size(), want.size());
    else passes++;
    for (int k = 0; k < want.size(); k++) begin
      got = (k < tx_got.size()) ? tx_got[k] : 8'hxx;
      checks++;
      if (got !== want[k]) $display("FAIL gap_byte%0d: got %h want %h", k, got, want[k]);
      else passes++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst_cap();
    test_backpressure();
    test_reset_mid();
    test_owner_gap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
